// File: rtl/ir_pkg.sv
// Shared types and defaults for the IR carrier path (sequencer and carrier generator).
package ir_pkg;

    localparam int IR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ir_state_t;

endpackage

// File: rtl/ir_shadow_reg.sv
// Double-buffered period/duty: shadow capture, pending flag and the apply mux
// that moves new settings into the active registers only at an apply point.
module ir_shadow_reg
    import ir_pkg::*;
#(
    parameter int WIDTH = IR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             update,
    input  logic             apply,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] active_period,
    output logic [WIDTH-1:0] next_period,
    output logic [WIDTH-1:0] next_duty
);

    logic [WIDTH-1:0] active_duty;
    logic [WIDTH-1:0] shadow_period;
    logic [WIDTH-1:0] shadow_duty;
    logic             pending;

    // A strobe on the apply cycle itself bypasses the shadow so it lands one period earlier.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        next_period = active_period;
        next_duty   = active_duty;
        if (apply) begin
            if (update) begin
                next_period = period;
                next_duty   = duty;
            end else if (pending) begin
                next_period = shadow_period;
                next_duty   = shadow_duty;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_period <= '0;
            active_duty   <= '0;
            shadow_period <= '0;
            shadow_duty   <= '0;
            pending       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            active_period <= next_period;
            active_duty   <= next_duty;
            if (update) begin
                shadow_period <= period;
                shadow_duty   <= duty;
            end
            if (apply) begin
                pending <= 1'b0;
            end else if (update) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ir_carrier_pwm.sv
// Glitch-free PWM carrier: period/duty change only on period boundaries, with an
// optional drain phase that lets the current period finish after enable drops.
module ir_carrier_pwm
    import ir_pkg::*;
#(
    parameter int WIDTH         = IR_WIDTH,
    parameter bit FINISH_PERIOD = 1'b1
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             enable_in,
    input  logic [WIDTH-1:0] period_in,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             update_in,
    output logic             pwm_out,
    output logic             period_end_out,
    output logic             busy_out
);

    ir_state_t        state;
    ir_state_t        state_next;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] active_period;
    logic [WIDTH-1:0] next_period;
    logic [WIDTH-1:0] next_duty;
    logic             boundary;
    logic             apply;
    logic             pwm_next;
    logic             period_end_next;

    assign boundary = (state != IDLE) && (count == active_period);
    assign apply    = (state == IDLE) || boundary;
    assign busy_out = (state != IDLE);

    ir_shadow_reg #(.WIDTH(WIDTH)) u_shadow (
        .clk           (clock_in),
        .rst           (reset_in),
        .update        (update_in),
        .apply         (apply),
        .period        (period_in),
        .duty          (duty_in),
        .active_period (active_period),
        .next_period   (next_period),
        .next_duty     (next_duty)
    );

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state          <= IDLE;
            count          <= '0;
            pwm_out        <= 1'b0;
            period_end_out <= 1'b0;
        end else begin
            state          <= state_next;
            count          <= count_next;
            pwm_out        <= pwm_next;
            period_end_out <= period_end_next;
        end
    end

    // RUN and DRAIN share transitions; DRAIN only records that enable has dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       state_next = enable_in ? RUN : IDLE;
            RUN, DRAIN: begin
                if (enable_in) begin
                    state_next = RUN;
                end else if (!FINISH_PERIOD || boundary) begin
                    state_next = IDLE;
                end else begin
                    state_next = DRAIN;
                end
            end
            default:    state_next = IDLE;
        endcase
    end

    // Outputs are registered from the post-edge counter and settings, so pwm_out
    // always reflects the period position it is labelled with.
    always_comb begin
        count_next      = '0;
        pwm_next        = 1'b0;
        period_end_next = 1'b0;
        if (state_next != IDLE) begin
            count_next      = apply ? '0 : count + WIDTH'(1);
            pwm_next        = (count_next < next_duty);
            period_end_next = (count_next == next_period);
        end
    end

endmodule

// File: tb/tb_ir_carrier_pwm.sv
// Bench for ir_carrier_pwm: both FINISH_PERIOD variants driven in lockstep and
// compared every cycle against a period-position reference model.
module tb_ir_carrier_pwm;

    localparam int W = 8;

    logic         clock_in = 1'b0;
    logic         reset_in = 1'b1;
    logic         enable_in = 1'b0;
    logic         update_in = 1'b0;
    logic [W-1:0] period_in = '0;
    logic [W-1:0] duty_in = '0;
    logic         pwm_f, pe_f, busy_f;
    logic         pwm_s, pe_s, busy_s;

    always #5 clock_in = ~clock_in;

    ir_carrier_pwm #(.WIDTH(W), .FINISH_PERIOD(1'b1)) dut_finish (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .enable_in      (enable_in),
        .period_in      (period_in),
        .duty_in        (duty_in),
        .update_in      (update_in),
        .pwm_out        (pwm_f),
        .period_end_out (pe_f),
        .busy_out       (busy_f)
    );

    ir_carrier_pwm #(.WIDTH(W), .FINISH_PERIOD(1'b0)) dut_stop (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .enable_in      (enable_in),
        .period_in      (period_in),
        .duty_in        (duty_in),
        .update_in      (update_in),
        .pwm_out        (pwm_s),
        .period_end_out (pe_s),
        .busy_out       (busy_s)
    );

    // Reference: "running" plus position k within a period of p+1 cycles.
    typedef struct {
        bit run;
        int k;
        int p;
        int d;
        int ps;
        int ds;
        bit pend;
    } model_t;

    model_t mf, ms;
    int vectors = 0;
    int miscompares = 0;
    int hi_cnt = 0;
    int pe_cnt = 0;

    function automatic model_t model_step(model_t m, bit finish, bit rst, bit en,
                                          bit upd, int pin, int din);
        model_t n = m;
        bit at_end;
        bit takes_new;
        if (rst) begin
            n = '{run: 0, k: 0, p: 0, d: 0, ps: 0, ds: 0, pend: 0};
            return n;
        end
        at_end    = m.run && (m.k == m.p);
        takes_new = !m.run || at_end;
        if (upd) begin
            n.ps = pin;
            n.ds = din;
            n.pend = 1;
        end
        if (takes_new) begin
            if (upd) begin
                n.p = pin;
                n.d = din;
            end else if (m.pend) begin
                n.p = m.ps;
                n.d = m.ds;
            end
            n.pend = 0;
        end
        if (!m.run) begin
            n.run = en;
            n.k = 0;
        end else if (en || (finish && !at_end)) begin
            n.run = 1;
            n.k = at_end ? 0 : m.k + 1;
        end else begin
            n.run = 0;
            n.k = 0;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: drive, clock, update models, then compare at the next negedge.
    task automatic step(input bit rst, input bit en, input bit upd, input int p, input int d);
        reset_in  = rst;
        enable_in = en;
        update_in = upd;
        period_in = p[W-1:0];
        duty_in   = d[W-1:0];
        @(posedge clock_in);
        mf = model_step(mf, 1'b1, rst, en, upd, p, d);
        ms = model_step(ms, 1'b0, rst, en, upd, p, d);
        @(negedge clock_in);
        check("pwm_finish",  32'(pwm_f),  32'(mf.run && (mf.k < mf.d)));
        check("pend_finish", 32'(pe_f),   32'(mf.run && (mf.k == mf.p)));
        check("busy_finish", 32'(busy_f), 32'(mf.run));
        check("pwm_stop",    32'(pwm_s),  32'(ms.run && (ms.k < ms.d)));
        check("pend_stop",   32'(pe_s),   32'(ms.run && (ms.k == ms.p)));
        check("busy_stop",   32'(busy_s), 32'(ms.run));
        hi_cnt += int'(pwm_f);
        pe_cnt += int'(pe_f);
    endtask

    task automatic run_cycles(input int n, input bit en);
        for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 0, 0);
    endtask

    initial begin
        bit en;
        bit upd;
        bit rst;
        int p;
        int d;
        mf = '{run: 0, k: 0, p: 0, d: 0, ps: 0, ds: 0, pend: 0};
        ms = mf;
        @(negedge clock_in);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        check("reset_pwm", 32'(pwm_f), 32'd0);
        check("reset_busy", 32'(busy_s), 32'd0);

        // P=9, D=3: 3 high / 7 low, end pulse every 10th cycle, first high after one edge.
        step(1'b0, 1'b0, 1'b1, 9, 3);
        hi_cnt = 0;
        pe_cnt = 0;
        step(1'b0, 1'b1, 1'b0, 0, 0);
        check("first_high", 32'(pwm_f), 32'd1);
        run_cycles(29, 1'b1);
        check("hi_per_30", 32'(hi_cnt), 32'd9);
        check("ends_per_30", 32'(pe_cnt), 32'd3);

        // Mid-period update to P=4/D=2: current period completes untouched.
        run_cycles(4, 1'b1);
        step(1'b0, 1'b1, 1'b1, 4, 2);
        run_cycles(30, 1'b1);

        // D=0 never high; D>P always high with period ends unchanged.
        step(1'b0, 1'b1, 1'b1, 9, 0);
        run_cycles(12, 1'b1);
        hi_cnt = 0;
        run_cycles(30, 1'b1);
        check("duty0_hi", 32'(hi_cnt), 32'd0);
        step(1'b0, 1'b1, 1'b1, 9, 12);
        run_cycles(12, 1'b1);
        hi_cnt = 0;
        pe_cnt = 0;
        run_cycles(30, 1'b1);
        check("duty_full_hi", 32'(hi_cnt), 32'd30);
        check("duty_full_ends", 32'(pe_cnt), 32'd3);

        // Disable/drain behaviour and re-enable during the drain.
        step(1'b0, 1'b1, 1'b1, 9, 3);
        run_cycles(13, 1'b1);
        run_cycles(12, 1'b0);
        run_cycles(13, 1'b1);
        run_cycles(3, 1'b0);
        run_cycles(15, 1'b1);

        // Reset mid-high-phase discards the pending update; restart runs at P=0/D=0.
        run_cycles(10, 1'b1);
        step(1'b0, 1'b1, 1'b1, 5, 2);
        step(1'b1, 1'b1, 1'b0, 0, 0);
        check("reset_mid_busy", 32'(busy_f), 32'd0);
        hi_cnt = 0;
        pe_cnt = 0;
        run_cycles(10, 1'b1);
        check("p0_hi", 32'(hi_cnt), 32'd0);
        check("p0_ends", 32'(pe_cnt), 32'd10);

        // Strobe exactly on boundary cycles so the bypass path is exercised repeatedly.
        step(1'b0, 1'b1, 1'b1, 6, 2);
        for (int i = 0; i < 80; i++) begin
            upd = mf.run && (mf.k == mf.p);
            p = $urandom_range(0, 7);
            d = $urandom_range(0, 9);
            step(1'b0, 1'b1, upd, p, d);
        end

        // Randomised traffic.
        en = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) en = ~en;
            upd = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) begin
                p = $urandom_range(0, 255);
                d = $urandom_range(0, 255);
            end else begin
                p = $urandom_range(0, 12);
                d = $urandom_range(0, 14);
            end
            step(rst, en, upd, p, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
